bidir_shift_pipe: RTL

- Pipelined, parametrised bidirectional shifter: the sequential successor to the team's combinational shifter.
- Adds arithmetic, logical and rotate modes, shift-amount clamping, and a valid/ready handshake with full backpressure.
- Applies one power-of-two shift per registered stage.
- Sits between datapath producers and consumers that need a throughput of one shift per cycle at high clock rates.

---
 rtl/bidir_shift_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bidir_shift_pipe.sv
// bidir_shift_pipe: pipelined log shifter, one power-of-two step per stage.
// Logical, arithmetic and rotate modes with valid/ready backpressure.
module bidir_shift_pipe #(
    parameter int WIDTH = 8,
    parameter int MAX_SHIFT = 7,
    localparam int SHW = $clog2(MAX_SHIFT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out_data,
    output logic             out_err
);
    localparam logic [1:0] M_ARI = 2'b01;
    localparam logic [1:0] M_ROT = 2'b10;
    localparam logic [1:0] M_RSV = 2'b11;
    localparam int CS = (SHW > 1) ? SHW - 1 : 1;

    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input logic             dir,
        input logic [1:0]       mode,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        fill = ~({WIDTH{1'b1}} >> amt);
        r = dir ? d >> amt : d << amt;
        unique case (1'b1)
            mode == M_ROT:
                r = dir ? (d >> amt) | (d << (WIDTH - amt))
                        : (d << amt) | (d >> (WIDTH - amt));
            mode == M_ARI && dir && d[WIDTH-1]:
                r = (d >> amt) | fill;
            default: ;
        endcase
        return r;
    endfunction

    logic             stall;
    logic             clamp;
    logic             rsv;
    logic             acc_err;
    logic [31:0]      shamt_ext;
    logic [SHW-1:0]   eff_amt;

    logic             vld_q  [SHW];
    logic             err_q  [SHW];
    logic [WIDTH-1:0] dat_q  [SHW];
    logic [WIDTH-1:0] dat_d  [SHW];
    logic             dir_q  [CS];
    logic [1:0]       mode_q [CS];
    logic [SHW-1:0]   amt_q  [CS];

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign shamt_ext = 32'(in_shamt);
    assign rsv       = (in_mode == M_RSV);
    assign clamp     = shamt_ext > 32'(MAX_SHIFT);
    assign acc_err   = rsv | clamp;
    assign eff_amt   = rsv   ? '0 :
                       clamp ? SHW'(MAX_SHIFT) : in_shamt;

    for (genvar k = 0; k < SHW; k++) begin : g_stg
        logic             vs;
        logic             es;
        logic             ds;
        logic             hit;
        logic [1:0]       ms;
        logic [SHW-1:0]   as;
        logic [WIDTH-1:0] xs;

        if (k == 0) begin : g_src
            assign vs = in_valid;
            assign es = acc_err;
            assign ds = in_dir;
            assign ms = in_mode;
            assign as = eff_amt;
            assign xs = in_data;
        end else begin : g_src
            assign vs = vld_q[k-1];
            assign es = err_q[k-1];
            assign ds = dir_q[k-1];
            assign ms = mode_q[k-1];
            assign as = amt_q[k-1];
            assign xs = dat_q[k-1];
        end

        // remaining amount is pre-shifted, so the last stage sees only bit 0
        if (k == SHW - 1) begin : g_hit
            assign hit = |as;
        end else begin : g_hit
            assign hit = as[0];
        end

        assign dat_d[k] = hit ? shift_by(xs, ds, ms, 1 << k) : xs;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q[k] <= 1'b0;
                err_q[k] <= 1'b0;
                dat_q[k] <= '0;
            end else if (!stall) begin
                vld_q[k] <= vs;
                err_q[k] <= es;
                dat_q[k] <= dat_d[k];
            end
        end

        if (k < SHW - 1) begin : g_ctl
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dir_q[k]  <= 1'b0;
                    mode_q[k] <= '0;
                    amt_q[k]  <= '0;
                end else if (!stall) begin
                    dir_q[k]  <= ds;
                    mode_q[k] <= ms;
                    amt_q[k]  <= as >> 1;
                end
            end
        end
    end

    assign out_valid = vld_q[SHW-1];
    assign out_err   = err_q[SHW-1];
    assign out_data  = dat_q[SHW-1];

endmodule
